// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: request/response bundle for the fetch PC sequencer.
//   master : the pipeline control side (drives stall/redirect/exception,
//            observes pc, pc_plus_inc, redirect_pending, align_err)
//   slave  : the pc_sequencer itself
// Handshake: redirect_valid and exc_valid are single-cycle requests with no
// ready; a request is consumed (or discarded by priority) at the rising edge
// of the cycle in which it is presented. Nothing is held by the requester.
interface pc_sequencer_if #(parameter int WIDTH = 32);
  logic             stall;
  logic             redirect_valid;
  logic [1:0]       redirect_sel;
  logic [WIDTH-1:0] jump_target;
  logic [WIDTH-1:0] branch_target;
  logic [WIDTH-1:0] jr_target;
  logic             exc_valid;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus_inc;
  logic             redirect_pending;
  logic             align_err;

  modport master (
    output stall, redirect_valid, redirect_sel, jump_target, branch_target,
           jr_target, exc_valid,
    input  pc, pc_plus_inc, redirect_pending, align_err
  );

  modport slave (
    input  stall, redirect_valid, redirect_sel, jump_target, branch_target,
           jr_target, exc_valid,
    output pc, pc_plus_inc, redirect_pending, align_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch program counter with next-PC selection.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - pc_sequencer_if.slave: stall, redirect_valid/sel, jump/branch/jr
//           targets, exc_valid in; pc, pc_plus_inc, redirect_pending,
//           align_err out.
// Priority per edge: exception > stall (buffer first redirect) > pending
// redirect > live redirect > sequential increment.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter int               INC        = 4,
  parameter int               ALIGN_BITS = 2,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_PC     = WIDTH'(32'h0000_0080)
) (
  input logic            clk,
  input logic            rst_n,
  pc_sequencer_if.slave  bus
);

  // Low target bits that must be zero; ALIGN_BITS=0 gives an empty mask.
  localparam logic [WIDTH-1:0] ALIGN_MASK =
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  localparam logic [1:0] SEL_JUMP   = 2'd0;
  localparam logic [1:0] SEL_SEQ    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_mis_q, pend_mis_d;
  logic             align_err_q, align_err_d;

  logic [WIDTH-1:0] sel_target;
  logic [WIDTH-1:0] aligned_target;
  logic             live_mis;
  logic             live_redirect;
  logic [WIDTH-1:0] pc_inc;

  // Target mux; sel=1 (sequential) never reaches the pc because
  // live_redirect is low for it, so its mux value is irrelevant.
  always_comb begin
    sel_target = bus.jr_target;
    case (bus.redirect_sel)
      SEL_JUMP:   sel_target = bus.jump_target;
      SEL_BRANCH: sel_target = bus.branch_target;
      default:    sel_target = bus.jr_target;
    endcase
  end

  assign live_redirect  = bus.redirect_valid && (bus.redirect_sel != SEL_SEQ);
  assign aligned_target = sel_target & ~ALIGN_MASK;
  assign live_mis       = |(sel_target & ALIGN_MASK);
  assign pc_inc         = pc_q + WIDTH'(INC);

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    pend_mis_d  = pend_mis_q;
    align_err_d = 1'b0;
    if (bus.exc_valid) begin
      pc_d   = EXC_PC;
      pend_d = 1'b0;
    end else if (bus.stall) begin
      // First redirect during a stall wins; later ones are dropped.
      if (live_redirect && !pend_q) begin
        pend_d     = 1'b1;
        pend_tgt_d = aligned_target;
        pend_mis_d = live_mis;
      end
    end else if (pend_q) begin
      // The buffered redirect takes precedence over any live one this cycle.
      pc_d        = pend_tgt_q;
      pend_d      = 1'b0;
      align_err_d = pend_mis_q;
    end else if (live_redirect) begin
      pc_d        = aligned_target;
      align_err_d = live_mis;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      pend_mis_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_mis_q  <= pend_mis_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.pc_plus_inc      = pc_inc;
  assign bus.redirect_pending = pend_q;
  assign bus.align_err        = align_err_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter sequencer for the MIPS pipeline fetch stage. It holds the architectural fetch PC and selects the next PC from four sources: sequential increment, jump target, branch target and register (JR) target, plus a non-stallable exception vector. Redirects that arrive while fetch is stalled are buffered and applied when the stall releases. Width, increment, reset vector and exception vector are parameters; the select encoding matches the existing PC_select convention.

## Interface
- WIDTH, 32, address width in bits
- INC, 4, sequential increment added to pc
- ALIGN_BITS, 2, low target bits that must be zero (0 disables alignment checking)
- RESET_PC, 32'h0000_0000, pc value after reset (WIDTH bits)
- EXC_PC, 32'h0000_0080, exception vector (WIDTH bits)

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold pc (fetch stall)
- redirect_valid  in  1  a redirect request is presented this cycle
- redirect_sel  in  2  0 jump, 1 sequential (no redirect), 2 branch, 3 JR
- jump_target  in  WIDTH  jump destination
- branch_target  in  WIDTH  branch destination
- jr_target  in  WIDTH  register-jump destination
- exc_valid  in  1  take exception vector; overrides stall
- pc  out  WIDTH  current fetch PC (registered)
- pc_plus_inc  out  WIDTH  pc + INC (combinational, modulo 2^WIDTH)
- redirect_pending  out  1  a buffered redirect is waiting for the stall to release
- align_err  out  1  one-cycle pulse: the applied redirect target had nonzero low bits

## Operation
- Reset (rst_n low, asynchronous): pc = RESET_PC, pending target = 0, redirect_pending = 0, align_err = 0.
- A live redirect is redirect_valid=1 with redirect_sel ∈ {0,2,3}. A live target is selected by redirect_sel. redirect_sel=1 with valid=1 is treated as no redirect.
- Aligned target: the selected target with bits [ALIGN_BITS-1:0] forced to 0. Misaligned means any of those bits was 1.
- Next-state priority, evaluated each edge:
  1. exc_valid: pc <= EXC_PC, regardless of stall. Clears redirect_pending. align_err <= 0.
  2. stall=1: pc holds. If a live redirect arrives and redirect_pending=0, capture its aligned target, set redirect_pending, and record its misalignment. If redirect_pending=1, the new redirect is discarded (first redirect wins).
  3. stall=0 and redirect_pending=1: pc <= pending target, clear redirect_pending, align_err <= recorded misalignment. A live redirect in the same cycle is discarded.
  4. stall=0 with a live redirect: pc <= aligned live target, align_err <= its misalignment.
  5. Otherwise: pc <= pc + INC, with wrap-around modulo 2^WIDTH.
- align_err is 0 in every cycle that is not case 3 or case 4.
- Wrap-around: when pc = 2^WIDTH − INC and the sequential path is taken, pc becomes 0. No error is flagged.

## Timing
- Latency: a redirect presented in cycle N with stall=0 appears on pc after edge N (visible in cycle N+1).
- Buffered redirect: it is captured at the first stalled edge. It appears on pc one cycle after the first edge where stall=0.
- Exception: applied at the very next edge, even under stall.
- Interaction between redirect_pending and pc:
  - redirect_pending rises on the capturing edge and falls on the applying edge, or on an exception edge.
  - pc is never updated by a pending redirect and a live redirect on the same edge.
- pc_plus_inc changes combinationally with pc. There is no extra latency.
- Reset mid-stall with a pending redirect: the pending redirect is lost. pc = RESET_PC immediately and it resumes sequential fetch on the first edge after rst_n rises.

## Test plan
- Reset and sequential fetch: release rst_n with stall=0 and no redirects. pc must go 0x0, 0x4, 0x8, 0xC on consecutive cycles, and pc_plus_inc must track pc+4.
- Each redirect source:
  - from pc=0x10, present sel=0 jump_target=0x400 → next pc = 0x400;
  - then sel=2 branch_target=0x1000 → 0x1000;
  - then sel=3 jr_target=0x2000 → 0x2000;
  - then sel=1 with valid=1 → 0x2004.
- Stall buffering:
  - hold stall for 3 cycles at pc=0x20;
  - present branch 0x300 in stall cycle 1 and jump 0x500 in stall cycle 2;
  - required response: redirect_pending=1, pc stays 0x20, then pc=0x300 after release, and 0x500 is never taken.
- Exception priority: with stall=1 and a pending redirect, assert exc_valid. Next pc must be 0x80 and redirect_pending must be 0. Then pc=0x84 with stall=0.
- Alignment: present jr_target=0x1003 with stall=0. pc must be 0x1000 and align_err must pulse for exactly one cycle. Repeat with the same target buffered under stall; the pulse must occur on the release edge.
- Wrap and async reset:
  - with WIDTH=16, pc=0xFFFC sequential → 0x0000;
  - drop rst_n mid-cycle during a stall with redirect_pending=1 → pc=RESET_PC and redirect_pending=0 immediately, with no clock edge.
